instruction_register: RTL

Fetch-side instruction latch and field splitter that feeds the immediate extender directly.
- Requests one 32-bit word from instruction memory per fetch, holds it under stall, and discards it on flush.
- Drives opcode and register fields downstream.
- Drives the three raw immediate slices (16/21/18 bit) and the 2-bit extender selection consumed by the extender.

---
 rtl/instruction_register_if.sv | 44 ++++
 rtl/instruction_register.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instruction_register_if.sv
// Fetch/memory/decode bundle between the fetch controller side and the instruction register.
interface instruction_register_if;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned OPC_W  = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMMA_W = 16;
  localparam int unsigned IMMB_W = 21;
  localparam int unsigned IMMC_W = 18;
  localparam int unsigned SEL_W  = 2;

  logic                fetchEnable;
  logic [WORD_W-1:0]   pcIn;
  logic                stall;
  logic                flush;
  logic                memRequest;
  logic [WORD_W-1:0]   memAddress;
  logic                memReady;
  logic [WORD_W-1:0]   memData;
  logic                instructionValid;
  logic [WORD_W-1:0]   instructionOut;
  logic [OPC_W-1:0]    opcode;
  logic [REG_W-1:0]    rs;
  logic [REG_W-1:0]    rt;
  logic [REG_W-1:0]    rd;
  logic [IMMA_W-1:0]   immediateA;
  logic [IMMB_W-1:0]   immediateB;
  logic [IMMC_W-1:0]   immediateC;
  logic [SEL_W-1:0]    extenderSelection;
  logic                fetchError;

  modport master (
    output fetchEnable, pcIn, stall, flush, memReady, memData,
    input  memRequest, memAddress, instructionValid, instructionOut,
           opcode, rs, rt, rd, immediateA, immediateB, immediateC,
           extenderSelection, fetchError
  );

  modport slave (
    input  fetchEnable, pcIn, stall, flush, memReady, memData,
    output memRequest, memAddress, instructionValid, instructionOut,
           opcode, rs, rt, rd, immediateA, immediateB, immediateC,
           extenderSelection, fetchError
  );
endinterface

// File: rtl/instruction_register.sv
// Fetch-side instruction latch: one memory request per fetch, hold under stall,
// drop on flush, split the held word into fields for decode and the extender.
module instruction_register #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  instruction_register_if.slave  bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    wait_count, wait_count_d;
  logic                request_q, request_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic [WORD_W-1:0]   address_q, address_d;
  logic [WORD_W-1:0]   instr_q, instr_d;
  logic                timeout_hit;

  assign timeout_hit = (wait_count == LAST_WAIT);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; flush overrides every state
  always_comb begin
    next_state = state;
    if (bus.flush) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.fetchEnable && !bus.stall) next_state = FETCH;
        FETCH:   if (bus.memReady)                  next_state = VALID;
                 else if (timeout_hit)              next_state = IDLE;
        VALID:   if (!bus.stall)                    next_state = bus.fetchEnable ? FETCH : IDLE;
        default:                                    next_state = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, counter and instruction latch
  always_comb begin
    request_d    = (next_state == FETCH);
    valid_d      = (next_state == VALID);
    address_d    = address_q;
    instr_d      = instr_q;
    wait_count_d = wait_count;
    error_d      = error_q;
    if (bus.flush) begin
      instr_d      = NOP_WORD;
      wait_count_d = '0;
    end else begin
      case (state)
        IDLE: begin
          if (next_state == FETCH) address_d = bus.pcIn;
        end
        FETCH: begin
          if (bus.memReady) begin
            instr_d      = bus.memData;
            wait_count_d = '0;
          end else if (timeout_hit) begin
            error_d      = 1'b1;
            instr_d      = NOP_WORD;
            wait_count_d = '0;
          end else begin
            wait_count_d = wait_count + CNT_W'(1);
          end
        end
        VALID: begin
          if (next_state == FETCH) address_d = bus.pcIn;
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      request_q  <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      address_q  <= '0;
      instr_q    <= NOP_WORD;
      wait_count <= '0;
    end else begin
      request_q  <= request_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      address_q  <= address_d;
      instr_q    <= instr_d;
      wait_count <= wait_count_d;
    end
  end

  // Extender format select from the opcode class bits
  always_comb begin
    case (instr_q[31:30])
      2'b01:   bus.extenderSelection = 2'b00;
      2'b10:   bus.extenderSelection = 2'b01;
      2'b11:   bus.extenderSelection = 2'b10;
      default: bus.extenderSelection = 2'b11;
    endcase
  end

  assign bus.memRequest       = request_q;
  assign bus.memAddress       = address_q;
  assign bus.instructionValid = valid_q;
  assign bus.instructionOut   = instr_q;
  assign bus.fetchError       = error_q;
  assign bus.opcode           = instr_q[31:26];
  assign bus.rs               = instr_q[25:21];
  assign bus.rt               = instr_q[20:16];
  assign bus.rd               = instr_q[15:11];
  assign bus.immediateA       = instr_q[15:0];
  assign bus.immediateB       = instr_q[20:0];
  assign bus.immediateC       = instr_q[17:0];

endmodule
